// File: rtl/snake_cpu_cpu_debug_mem_sequencer_pkg.sv
// Shared types and jdo field positions for the debug-memory sequencer.
package snake_cpu_cpu_debug_pkg;

  typedef enum logic [2:0] {
    IDLE, J_WR, J_RD, J_CAP, C_WR, C_RD, C_CAP
  } seq_state_e;

  typedef enum logic {
    OP_RD = 1'b0,
    OP_WR = 1'b1
  } jop_e;

  localparam int JDO_ADDR_LSB  = 17;
  localparam int JDO_RDREQ_BIT = 34;
  localparam int JDO_WDATA_MSB = 34;
  localparam int JDO_WDATA_LSB = 3;

  // Requester indices on the arbiter
  localparam int RR_JTAG = 0;
  localparam int RR_CPU  = 1;

endpackage

// File: rtl/snake_cpu_cpu_debug_mem_sequencer_if.sv
// CPU-side Avalon-MM debug-memory port.
interface snake_cpu_cpu_debug_mem_sequencer_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] cpu_address;
  logic              cpu_read;
  logic              cpu_write;
  logic [DATA_W-1:0] cpu_writedata;
  logic              cpu_waitrequest;
  logic [DATA_W-1:0] cpu_readdata;

  modport master (
    output cpu_address, cpu_read, cpu_write, cpu_writedata,
    input  cpu_waitrequest, cpu_readdata
  );

  modport slave (
    input  cpu_address, cpu_read, cpu_write, cpu_writedata,
    output cpu_waitrequest, cpu_readdata
  );
endinterface

// File: rtl/snake_cpu_cpu_debug_rr_arb.sv
// Two-requester round-robin arbiter; the favoured side flips only on a contended grant.
module snake_cpu_cpu_debug_rr_arb (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic ptr;

  always_comb begin
    gnt = '0;
    if (&req) gnt[ptr] = 1'b1;
    else      gnt = req;
  end

  always_ff @(posedge clk) begin
    if (reset)                ptr <= 1'b0;
    else if (advance && &req) ptr <= ~ptr;
  end

endmodule

// File: rtl/snake_cpu_cpu_debug_mem_sequencer.sv
// Shares one single-port debug RAM between JTAG debug commands and the CPU
// Avalon slave; JTAG keeps an auto-incrementing address and status flags.
module snake_cpu_cpu_debug_mem_sequencer
  import snake_cpu_cpu_debug_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [37:0]         jdo,
  input  logic                take_action_ocimem_a,
  input  logic                take_action_ocimem_b,
  input  logic                take_no_action_ocimem_a,
  snake_cpu_cpu_debug_mem_sequencer_if.slave cpu,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic                ram_wr,
  output logic [DATA_W-1:0]   ram_wdata,
  input  logic [DATA_W-1:0]   ram_rdata,
  output logic [DATA_W-1:0]   MonDReg,
  output logic                monitor_ready,
  output logic                monitor_error
);

  seq_state_e        state, state_nxt;
  logic [ADDR_W-1:0] jaddr;
  logic              jpend;
  jop_e              jop;
  logic [DATA_W-1:0] jwdata;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic              cpu_req, cpu_done;
  logic              any_strobe, strobe_op;
  logic [1:0]        gnt;
  logic              jdo_unused;

  assign jdo_unused = ^{jdo[37:35], jdo[2:0]};

  assign cpu_req    = cpu.cpu_read | cpu.cpu_write;
  assign cpu_done   = (state == C_WR) || (state == C_CAP);
  assign any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
  assign strobe_op  = (take_action_ocimem_a & jdo[JDO_RDREQ_BIT]) |
                      take_action_ocimem_b | take_no_action_ocimem_a;

  assign cpu.cpu_waitrequest = cpu_req & ~cpu_done;
  // Read data is forwarded straight from the RAM in the capture cycle so it is
  // valid while waitrequest is low; the register holds it afterwards.
  assign cpu.cpu_readdata = (state == C_CAP) ? ram_rdata : cpu_rdata_q;

  snake_cpu_cpu_debug_rr_arb u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     ({cpu_req, jpend}),
    .advance (state == IDLE),
    .gnt     (gnt)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (gnt[RR_JTAG])     state_nxt = (jop == OP_WR) ? J_WR : J_RD;
        else if (gnt[RR_CPU]) state_nxt = cpu.cpu_write ? C_WR : C_RD;
      end
      J_RD:    state_nxt = J_CAP;
      C_RD:    state_nxt = C_CAP;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      jaddr         <= '0;
      jpend         <= 1'b0;
      jop           <= OP_RD;
      jwdata        <= '0;
      MonDReg       <= '0;
      monitor_ready <= 1'b1;
      monitor_error <= 1'b0;
      ram_addr      <= '0;
      ram_wr        <= 1'b0;
      ram_wdata     <= '0;
      cpu_rdata_q   <= '0;
    end else begin
      state  <= state_nxt;
      // RAM port is registered off the next state so it lines up with the access state
      ram_wr <= (state_nxt == J_WR) || (state_nxt == C_WR);
      case (state_nxt)
        J_WR, J_RD: ram_addr <= jaddr;
        C_WR, C_RD: ram_addr <= cpu.cpu_address;
        default: ;
      endcase
      if (state_nxt == J_WR)      ram_wdata <= jwdata;
      else if (state_nxt == C_WR) ram_wdata <= cpu.cpu_writedata;

      if (state == J_CAP) MonDReg     <= ram_rdata;
      if (state == C_CAP) cpu_rdata_q <= ram_rdata;

      if (state == J_WR || state == J_CAP) begin
        jaddr         <= jaddr + 1'b1;
        jpend         <= 1'b0;
        monitor_ready <= 1'b1;
      end

      // jpend stays set until the op retires, so it also covers the in-flight window
      if (any_strobe) begin
        if (jpend) begin
          monitor_error <= 1'b1;
        end else begin
          if (take_action_ocimem_a) jaddr <= jdo[JDO_ADDR_LSB +: ADDR_W];
          if (strobe_op) begin
            jpend         <= 1'b1;
            monitor_ready <= 1'b0;
            jop           <= take_action_ocimem_b ? OP_WR : OP_RD;
            jwdata        <= jdo[JDO_WDATA_MSB:JDO_WDATA_LSB];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_snake_cpu_cpu_debug_mem_sequencer.sv
// Directed bench: latency/scoreboard model of the JTAG and CPU paths plus literal pins.
module tb_snake_cpu_cpu_debug_mem_sequencer;

  localparam int INF = 1 << 30;
  localparam int K_A = 0, K_B = 1, K_N = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [37:0] jdo = '0;
  logic        ta_a = 1'b0, ta_b = 1'b0, tn_a = 1'b0;
  logic [7:0]  ram_addr;
  logic        ram_wr;
  logic [31:0] ram_wdata, ram_rdata, MonDReg;
  logic        monitor_ready, monitor_error;

  snake_cpu_cpu_debug_mem_sequencer_if #(.ADDR_W(8), .DATA_W(32)) cpu_bus ();

  snake_cpu_cpu_debug_mem_sequencer #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (ta_a),
    .take_action_ocimem_b    (ta_b),
    .take_no_action_ocimem_a (tn_a),
    .cpu                     (cpu_bus),
    .ram_addr                (ram_addr),
    .ram_wr                  (ram_wr),
    .ram_wdata               (ram_wdata),
    .ram_rdata               (ram_rdata),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Debug RAM: one-cycle synchronous read
  logic [31:0] mem [256];
  int wr_seen = 0;
  always @(posedge clk) begin
    if (ram_wr) begin
      mem[ram_addr] <= ram_wdata;
      wr_seen       <= wr_seen + 1;
    end
    ram_rdata <= mem[ram_addr];
  end

  // Model: JTAG ops become busy the cycle after the strobe and retire after a
  // fixed latency (3 write / 4 read) plus any cycles lost to a CPU grant.
  int          m_clear_at = 0, m_done_at = 0, m_err_at = INF;
  logic [31:0] m_mon_old = '0, m_mon_new = '0;
  logic [7:0]  m_jaddr = '0;
  logic [31:0] exp_mem [256];
  int          exp_writes = 0;
  int          checks = 0, errors = 0;

  function automatic bit exp_ready(input int c);
    return !(c >= m_clear_at && c < m_done_at);
  endfunction
  function automatic logic [31:0] exp_mon(input int c);
    return (c >= m_done_at) ? m_mon_new : m_mon_old;
  endfunction
  function automatic bit exp_err(input int c);
    return c >= m_err_at;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      check("monitor_ready", 64'(monitor_ready), 64'(exp_ready(cyc)));
      check("monitor_error", 64'(monitor_error), 64'(exp_err(cyc)));
      check("MonDReg", 64'(MonDReg), 64'(exp_mon(cyc)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    m_clear_at = 0; m_done_at = 0; m_err_at = INF;
    m_mon_old = '0; m_mon_new = '0; m_jaddr = '0;
    reset = 1'b0;
  endtask

  task automatic jstrobe(input int kind, input logic [31:0] val, input bit rd, input int extra);
    int c;
    bit is_op, is_wr;
    c = cyc;
    case (kind)
      K_A:     begin ta_a = 1'b1; jdo = (38'(rd) << 34) | (38'(val[7:0]) << 17); end
      K_B:     begin ta_b = 1'b1; jdo = 38'(val) << 3; end
      default: begin tn_a = 1'b1; jdo = '0; end
    endcase
    if (!exp_ready(c)) begin
      if (m_err_at > c + 1) m_err_at = c + 1;
    end else begin
      if (kind == K_A) m_jaddr = val[7:0];
      is_op = (kind != K_A) || rd;
      is_wr = (kind == K_B);
      if (is_op) begin
        m_mon_old = exp_mon(c);
        m_mon_new = is_wr ? m_mon_old : exp_mem[m_jaddr];
        if (is_wr) begin
          exp_mem[m_jaddr] = val;
          exp_writes++;
        end
        m_clear_at = c + 1;
        m_done_at  = c + (is_wr ? 3 : 4) + extra;
        m_jaddr    = m_jaddr + 8'd1;
      end
    end
    tick();
    ta_a = 1'b0; ta_b = 1'b0; tn_a = 1'b0;
  endtask

  task automatic measure_ready(input int s, input string name, input int exp_lat);
    int t;
    t = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (monitor_ready) begin
        t = cyc - s;
        break;
      end
    end
    tick();
    check(name, 64'(t), 64'(exp_lat));
  endtask

  task automatic cpu_access(input bit wr, input logic [7:0] a, input logic [31:0] d,
                            input int exp_lat, input string name);
    int c, t;
    logic [31:0] rd;
    c = cyc; t = -1; rd = '0;
    cpu_bus.cpu_address   = a;
    cpu_bus.cpu_write     = wr;
    cpu_bus.cpu_read      = !wr;
    cpu_bus.cpu_writedata = d;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!cpu_bus.cpu_waitrequest) begin
        t  = cyc - c;
        rd = cpu_bus.cpu_readdata;
        break;
      end
    end
    tick();
    cpu_bus.cpu_read  = 1'b0;
    cpu_bus.cpu_write = 1'b0;
    check({name, " latency"}, 64'(t), 64'(exp_lat));
    if (wr) begin
      exp_mem[a] = d;
      exp_writes++;
    end else begin
      check({name, " data"}, 64'(rd), 64'(exp_mem[a]));
    end
  endtask

  initial begin
    int s, ws, bad;
    for (int i = 0; i < 256; i++) begin
      mem[i]     = (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
      exp_mem[i] = (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
    end
    cpu_bus.cpu_address = '0; cpu_bus.cpu_read = 1'b0;
    cpu_bus.cpu_write = 1'b0; cpu_bus.cpu_writedata = '0;

    do_reset();
    @(negedge clk);
    check("rst ram_wr", 64'(ram_wr), 64'd0);
    check("rst ram_addr", 64'(ram_addr), 64'd0);
    check("rst cpu_readdata", 64'(cpu_bus.cpu_readdata), 64'd0);
    check("rst waitrequest", 64'(cpu_bus.cpu_waitrequest), 64'd0);
    check("rst MonDReg", 64'(MonDReg), 64'd0);
    tick();

    // Address load then write
    jstrobe(K_A, 32'h10, 1'b0, 0);
    s = cyc;
    jstrobe(K_B, 32'hDEAD_BEEF, 1'b0, 0);
    measure_ready(s, "jtag wr latency", 3);
    check("ram[10]", 64'(mem[8'h10]), 64'hDEAD_BEEF);

    // Address load with read
    s = cyc;
    jstrobe(K_A, 32'h10, 1'b1, 0);
    measure_ready(s, "jtag rd latency", 4);
    check("MonDReg rd 10", 64'(MonDReg), 64'hDEAD_BEEF);

    // Wrap: write at FF, then read lands on 00
    jstrobe(K_A, 32'hFF, 1'b0, 0);
    s = cyc;
    jstrobe(K_B, 32'h1234_5678, 1'b0, 0);
    measure_ready(s, "jtag wr FF latency", 3);
    check("ram[FF]", 64'(mem[8'hFF]), 64'h1234_5678);
    s = cyc;
    jstrobe(K_N, 32'h0, 1'b0, 0);
    measure_ready(s, "jtag rd wrap latency", 4);
    check("MonDReg wrap", 64'(MonDReg), 64'hA5A5_0000);

    // Contention: JTAG favoured first, then CPU on the next contended pair
    jstrobe(K_B, 32'hCAFE_0001, 1'b0, 0);
    cpu_access(1'b0, 8'h10, 32'h0, 4, "cpu rd contended1");
    repeat (3) tick();
    jstrobe(K_B, 32'h0BAD_F00D, 1'b0, 3);
    cpu_access(1'b0, 8'hFF, 32'h0, 2, "cpu rd contended2");
    repeat (4) tick();
    check("ram[01]", 64'(mem[8'h01]), 64'hCAFE_0001);
    check("ram[02]", 64'(mem[8'h02]), 64'h0BAD_F00D);

    // Plain CPU write then read back
    cpu_access(1'b1, 8'h20, 32'h1111_2222, 1, "cpu wr");
    cpu_access(1'b0, 8'h20, 32'h0, 2, "cpu rd back");
    tick();

    // Overrun: second write one cycle later is dropped
    jstrobe(K_B, 32'hAAAA_5555, 1'b0, 0);
    jstrobe(K_B, 32'h5555_AAAA, 1'b0, 0);
    repeat (5) tick();
    check("overrun error", 64'(monitor_error), 64'd1);
    check("ram[03]", 64'(mem[8'h03]), 64'hAAAA_5555);
    check("ram[04] untouched", 64'(mem[8'h04]), 64'hA1A1_0404);

    // Reset during the J_RD cycle
    do_reset();
    jstrobe(K_A, 32'h05, 1'b1, 0);
    tick();
    ws = wr_seen;
    do_reset();
    @(negedge clk);
    check("midrst MonDReg", 64'(MonDReg), 64'd0);
    check("midrst ready", 64'(monitor_ready), 64'd1);
    check("midrst ram_wr", 64'(ram_wr), 64'd0);
    tick();
    repeat (3) tick();
    check("midrst no write", 64'(wr_seen), 64'(ws));
    s = cyc;
    jstrobe(K_N, 32'h0, 1'b0, 0);
    measure_ready(s, "post-rst rd latency", 4);
    check("post-rst MonDReg", 64'(MonDReg), 64'hA5A5_0000);

    repeat (3) tick();
    bad = 0;
    for (int i = 0; i < 256; i++) if (mem[i] !== exp_mem[i]) bad++;
    check("ram image mismatches", 64'(bad), 64'd0);
    check("ram write count", 64'(wr_seen), 64'(exp_writes));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
